// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the 3x3 systolic array feeder, array and bench.
package systolic_feeder_pkg;
  localparam int N      = 3;
  localparam int N_ELEM = N * N;

  localparam logic LD_SEL_A = 1'b0;
  localparam logic LD_SEL_B = 1'b1;

  // Skew depth 3 plus one MAC stage
  localparam int DEF_CLR_CYCLES   = 1;
  localparam int DEF_DRAIN_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;
endpackage

// File: rtl/systolic_operand_store.sv
// Operand register file for matrices A and B, with column-of-A / row-of-B read by beat k.
module systolic_operand_store
  import systolic_feeder_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic                 sel_i,
  input  logic [3:0]           addr_i,
  input  logic [DW-1:0]        data_i,
  input  logic [1:0]           k_i,
  output logic [N-1:0][DW-1:0] a_col_o,
  output logic [N-1:0][DW-1:0] b_row_o
);
  logic [DW-1:0] a_q [N_ELEM];
  logic [DW-1:0] b_q [N_ELEM];

  // Addresses 9..15 complete the handshake upstream but land nowhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < N_ELEM; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
    end else if (we_i && (addr_i < 4'(N_ELEM))) begin
      if (sel_i == LD_SEL_B) b_q[addr_i] <= data_i;
      else                   a_q[addr_i] <= data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_col_o[i] = a_q[i*N + int'(k_i)];
      b_row_o[i] = b_q[int'(k_i)*N + i];
    end
  end
endmodule

// File: rtl/systolic_feeder.sv
// Run sequencer: clears the MACs, streams aligned A columns / B rows, waits out the array pipeline.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DW           = 32,
  parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [3:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mac_clr,
  output logic [DW-1:0] dataa1,
  output logic [DW-1:0] dataa2,
  output logic [DW-1:0] dataa3,
  output logic [DW-1:0] datab1,
  output logic [DW-1:0] datab2,
  output logic [DW-1:0] datab3
);
  localparam int            CW         = 8;
  localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  feeder_state_e        state_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           k_q;
  logic                 busy_q, done_q, mac_clr_q;
  logic [N-1:0][DW-1:0] dataa_q, datab_q;
  logic [N-1:0][DW-1:0] a_col, b_row;

  assign ld_ready = (state_q == ST_IDLE);

  systolic_operand_store #(.DW(DW)) u_store (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ld_valid & ld_ready),
    .sel_i   (ld_sel),
    .addr_i  (ld_addr),
    .data_i  (ld_data),
    .k_i     (k_q),
    .a_col_o (a_col),
    .b_row_o (b_row)
  );

  // Outputs are registered from the current state, so they trail it by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      dataa_q   <= '0;
      datab_q   <= '0;
    end else begin
      mac_clr_q <= (state_q == ST_CLEAR);
      done_q    <= (state_q == ST_DONE);
      if (state_q == ST_STREAM) begin
        dataa_q <= a_col;
        datab_q <= b_row;
      end else begin
        dataa_q <= '0;
        datab_q <= '0;
      end
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_CLEAR;
          cnt_q   <= CLR_LOAD;
          busy_q  <= 1'b1;
        end
        ST_CLEAR: if (cnt_q == '0) begin
          state_q <= ST_STREAM;
          k_q     <= '0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        ST_STREAM: if (k_q == 2'(N - 1)) begin
          state_q <= ST_DRAIN;
          cnt_q   <= DRAIN_LOAD;
        end else begin
          k_q <= k_q + 1'b1;
        end
        ST_DRAIN: if (cnt_q == '0) state_q <= ST_DONE;
                  else             cnt_q   <= cnt_q - 1'b1;
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mac_clr = mac_clr_q;
  assign dataa1  = dataa_q[0];
  assign dataa2  = dataa_q[1];
  assign dataa3  = dataa_q[2];
  assign datab1  = datab_q[0];
  assign datab2  = datab_q[1];
  assign datab3  = datab_q[2];
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder; a behavioural MAC grid turns the streamed beats into C.
module tb_systolic_feeder;
  localparam int DW  = 32;
  localparam int WIN = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_ready, ld_sel;
  logic [3:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic          start, busy, done, mac_clr;
  logic [DW-1:0] dataa1, dataa2, dataa3, datab1, datab2, datab3;

  int n_checks = 0;
  int n_errors = 0;

  logic          cap_clr  [WIN];
  logic          cap_done [WIN];
  logic          cap_busy [WIN];
  logic [DW-1:0] cap_a    [WIN][3];
  logic [DW-1:0] cap_b    [WIN][3];
  longint        acc      [3][3];
  int            done_cnt;

  int exp_ida [3][3] = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
  int exp_idb [3][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}};
  int exp_gen [3][3] = '{'{30,24,18}, '{84,69,54}, '{138,114,90}};

  systolic_feeder #(.DW(DW), .CLR_CYCLES(1), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .mac_clr(mac_clr),
    .dataa1(dataa1), .dataa2(dataa2), .dataa3(dataa3),
    .datab1(datab1), .datab2(datab2), .datab3(datab3)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [3:0] addr, input logic [DW-1:0] val);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = val;
    #1;
    check_val("ld_ready_idle", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
  endtask

  // Start one run, then sample WIN cycles after the start edge; optionally inject
  // a second start (restart_at) or a B load beat (load_at) at a given sample index.
  task automatic run_capture(input int restart_at, input int load_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < WIN; n++) begin
      cap_clr[n]  = mac_clr;
      cap_done[n] = done;
      cap_busy[n] = busy;
      cap_a[n][0] = dataa1; cap_a[n][1] = dataa2; cap_a[n][2] = dataa3;
      cap_b[n][0] = datab1; cap_b[n][1] = datab2; cap_b[n][2] = datab3;
      if (done) done_cnt++;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          if (mac_clr) acc[i][j] = 0;
          else acc[i][j] += longint'(cap_a[n][i]) * longint'(cap_b[n][j]);
      ld_valid = 1'b0;
      start    = (n == restart_at);
      if (n == load_at) begin
        ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd0; ld_data = 32'h55;
        check_val("ld_ready_drain", ld_ready, 0);
      end
      tick();
    end
    ld_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_timing(input string tag);
    check_val({tag, "_clr0"},  cap_clr[0], 0);
    check_val({tag, "_clr1"},  cap_clr[1], 1);
    check_val({tag, "_clr2"},  cap_clr[2], 0);
    check_val({tag, "_busy0"}, cap_busy[0], 1);
    check_val({tag, "_busy8"}, cap_busy[8], 1);
    check_val({tag, "_busy9"}, cap_busy[9], 0);
    check_val({tag, "_done8"}, cap_done[8], 0);
    check_val({tag, "_done9"}, cap_done[9], 1);
    check_val({tag, "_ndone"}, done_cnt, 1);
    check_val({tag, "_drain"}, cap_a[5][0] | cap_b[5][2], 0);
  endtask

  task automatic check_c(input string tag, input int exp [3][3]);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check_val($sformatf("%s_c%0d%0d", tag, i, j), acc[i][j], exp[i][j]);
  endtask

  initial begin
    int tmp [3][3];
    int seen;
    rst = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) acc[i][j] = 0;
    tick(); tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_clr", mac_clr, 0);
    check_val("rst_da1", dataa1, 0);
    check_val("rst_db3", datab3, 0);
    check_val("rst_ready", ld_ready, 1);
    rst = 1'b1;
    tick();

    // Identity run: C must equal B
    for (int e = 0; e < 9; e++) load(1'b0, 4'(e), (e % 4 == 0) ? 32'd1 : 32'd0);
    for (int e = 0; e < 9; e++) load(1'b1, 4'(e), 32'(e + 1));
    run_capture(-1, -1);
    check_timing("id");
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("id_a%0d_k%0d", i, k), cap_a[2+k][i], exp_ida[k][i]);
        check_val($sformatf("id_b%0d_k%0d", i, k), cap_b[2+k][i], exp_idb[k][i]);
      end
    check_c("id", exp_idb);

    // General product
    for (int e = 0; e < 9; e++) load(1'b0, 4'(e), 32'(e + 1));
    for (int e = 0; e < 9; e++) load(1'b1, 4'(e), 32'(9 - e));
    run_capture(-1, -1);
    check_timing("gen");
    check_c("gen", exp_gen);

    // Second start during STREAM, B load during DRAIN
    run_capture(2, 5);
    check_timing("busy");
    check_c("busy", exp_gen);

    // Out-of-range address: handshake only, rerun identical
    load(1'b0, 4'd12, 32'hDEADBEEF);
    run_capture(-1, -1);
    check_timing("guard");
    check_c("guard", exp_gen);

    // Load beat in the same cycle as start
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 32'd7;
    run_capture(-1, -1);
    check_val("simul_da1", cap_a[2][0], 7);
    check_val("simul_done", done_cnt, 1);

    // Reset while streaming beat k=1
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check_val("mid_da1_pre", dataa1, 7);
    rst = 1'b0;
    #1;
    check_val("mid_busy", busy, 0);
    check_val("mid_da1", dataa1, 0);
    check_val("mid_db2", datab2, 0);
    check_val("mid_clr", mac_clr, 0);
    tick(); tick();
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) seen++;
    end
    check_val("mid_nodone", seen, 0);
    check_val("mid_ready", ld_ready, 1);
    run_capture(-1, -1);
    check_timing("post");
    check_val("post_da1", cap_a[2][0], 0);
    check_val("post_db1", cap_b[2][0], 0);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) tmp[i][j] = 0;
    check_c("post", tmp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Source side of the 3x3 systolic multiplier: buffers operand matrices A and B and streams them into the array's dataa1..3 / datab1..3 inputs.
- Clears the MAC accumulators before each run and signals when the array outputs hold the finished product C = A x B.
- Sits between the host load interface and the array; the array's internal skew registers handle wavefront alignment, so the feeder presents aligned columns of A and rows of B.

Parameters:
- DW, 32: operand width in bits.
- CLR_CYCLES, 1: cycles mac_clr is held high before streaming (>=1).
- DRAIN_CYCLES, 4: cycles after the last operand beat until the array outputs are final (array skew depth 3 + MAC latency 1).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid & ld_ready.
- ld_sel  in  1  0 selects matrix A, 1 selects matrix B.
- ld_addr  in  4  element index, row-major 0..8.
- ld_data  in  DW  element value.
- start  in  1  single-cycle run request.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; array outputs are final.
- mac_clr  out  1  active-high accumulator clear to the array.
- dataa1, dataa2, dataa3  out  DW  A column feed to array rows 1..3.
- datab1, datab2, datab3  out  DW  B row feed to array columns 1..3.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all 18 storage words go to 0.
  - busy, done, mac_clr and all data outputs go to 0.
  - Applies mid-run too: the run is abandoned and done is not asserted.
- All outputs are registered except ld_ready, which equals (state==IDLE).
- Load:
  - A beat is accepted only in IDLE.
  - Writes A[ld_addr] or B[ld_addr] at the clock edge.
  - ld_addr 9..15 is accepted (handshake completes) but writes nothing.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE -> CLEAR: start=1 in IDLE.
  - start is ignored in all other states; there is no queuing.
  - A load beat in the same cycle as start is committed, and its value is used by the run.
- CLEAR, for CLR_CYCLES cycles:
  - mac_clr=1, data outputs 0, busy=1.
  - Exit to STREAM with k=0.
- STREAM, 3 cycles, k=0,1,2:
  - dataa_i = A[i-1][k] and datab_j = B[k][j-1]; mac_clr=0.
  - Exit to DRAIN after k=2.
- DRAIN, DRAIN_CYCLES cycles: data outputs 0, so no spurious accumulation.
- DONE, 1 cycle: done=1, busy=0; next state IDLE.
- Timing: if start is sampled at edge E0, the first STREAM beat is visible after edge E0+CLR_CYCLES+1. done is high during the cycle following edge E0+CLR_CYCLES+3+DRAIN_CYCLES+1, which is 9 cycles after start with defaults.
- Between runs the data outputs remain 0 and the array accumulators keep their result until the next mac_clr.
- Storage is not cleared by a run; the same matrices can be rerun, or partially reloaded and rerun.
- No arithmetic is performed; operands pass through unmodified at DW bits.

Decomposition:
- Shared package:
  - FSM state enum.
  - Matrix dimension constant N=3.
  - Constants LD_SEL_A=0 and LD_SEL_B=1.
  - Default latency constants, reused by the array and its bench.
- Natural sub-module: systolic_operand_store. It holds the 2x9xDW register file, does the load write, and provides the combinational column/row read by k.
- Top-level systolic_feeder holds the FSM, counters and output registers.

Test Plan:
- Identity run:
  - Stimulus: load A=I, B=[1..9], start.
  - Response: mac_clr high 1 cycle, then 3 beats (dataa=1,0,0 / datab=1,2,3), then (0,1,0 / 4,5,6), then (0,0,1 / 7,8,9).
  - done exactly 9 cycles after start; through the array C equals B.
- General product:
  - Stimulus: A=[1..9], B=[9..1] (row-major).
  - Response: array result C = [30,24,18; 84,69,54; 138,114,90] at done.
- Busy protection:
  - Stimulus: a second start during STREAM, and a load beat during DRAIN.
  - Response: both ignored, ld_ready=0 in DRAIN, stored B unchanged, one done pulse only.
- Address guard:
  - Stimulus: write A addr 12 with 0xDEADBEEF.
  - Response: handshake completes, all A words unchanged, next run output identical to the previous one.
- Simultaneous load/start:
  - Stimulus: in IDLE, ld_valid with A[0]=7 plus start in the same cycle.
  - Response: the first STREAM beat shows dataa1=7.
- Reset mid-run:
  - Stimulus: rst=0 during STREAM k=1.
  - Response: all outputs 0 immediately, no done, ld_ready=1 after release, storage reads 0 on the next run.
